// File: rtl/dffram_wb_dp.sv
// Wishbone flip-flop RAM with a second read-only accelerator port (1-cycle latency on both).
// Optional post-reset zeroing engine enabled by defining DFFRAM_WB_DP_CLEAR_EN.
module dffram_wb_dp #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          DWIDTH       = 24,
    parameter int          AWIDTH       = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [31:0]       wb_adr_i,
    output logic              wb_ack_o,
    output logic [31:0]       wb_dat_o,
    input  logic              acc_rd_en_i,
    input  logic [AWIDTH-1:0] acc_rd_addr_i,
    output logic [DWIDTH-1:0] acc_rd_data_o,
    output logic              acc_rd_valid_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_r [DEPTH];

    logic              hit_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              busy_s;
    logic              clear_we_s;
    logic              unused_s;
    logic [AWIDTH-1:0] word_idx_s;
    logic [AWIDTH-1:0] clr_addr_s;
    logic [DWIDTH-1:0] wr_mask_s;
    logic [DWIDTH-1:0] wr_data_s;
    logic [31:0]       rd_word_s;

    logic              ack_r;
    logic [31:0]       dat_r;
    logic [DWIDTH-1:0] acc_data_r;
    logic              acc_valid_r;

    assign hit_s      = wb_cyc_i & wb_stb_i &
                        (wb_adr_i[31:AWIDTH+2] == BASE_ADDRESS[31:AWIDTH+2]);
    assign word_idx_s = wb_adr_i[AWIDTH+1:2];
    // Reset also blocks accepts so an access presented during reset never acks.
    assign accept_s   = hit_s & ~ack_r & ~busy_s & ~wb_rst_i;
    assign wr_en_s    = accept_s & wb_we_i;
    assign rd_en_s    = accept_s & ~wb_we_i;
    assign wr_data_s  = wb_dat_i[DWIDTH-1:0];
    assign unused_s   = ^{wb_adr_i[1:0], wb_sel_i, wb_dat_i};

    for (genvar g = 0; g < DWIDTH; g++) begin : g_mask
        assign wr_mask_s[g] = wb_sel_i[g/8];
    end

    // Zero-extend the addressed word to the bus width.
    always_comb begin
        rd_word_s                = 32'h0000_0000;
        rd_word_s[DWIDTH-1:0]    = mem_r[word_idx_s];
    end

    // Storage array: clear engine has priority, otherwise byte-lane Wishbone writes.
    always_ff @(posedge wb_clk_i) begin
        if (clear_we_s) begin
            mem_r[clr_addr_s] <= '0;
        end else if (wr_en_s) begin
            mem_r[word_idx_s] <= (mem_r[word_idx_s] & ~wr_mask_s) | (wr_data_s & wr_mask_s);
        end
    end

    // Wishbone ack and read-data registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= accept_s;
            if (rd_en_s) begin
                dat_r <= rd_word_s;
            end
        end
    end

    // Accelerator read pipeline; reads before a same-cycle write return the old word.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            acc_data_r  <= '0;
            acc_valid_r <= 1'b0;
        end else begin
            acc_valid_r <= acc_rd_en_i & ~busy_s;
            if (acc_rd_en_i & ~busy_s) begin
                acc_data_r <= mem_r[acc_rd_addr_i];
            end
        end
    end

`ifdef DFFRAM_WB_DP_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [AWIDTH-1:0] clr_cnt_r;
    logic [AWIDTH-1:0] clr_cnt_next_s;
    logic              busy_r;

    // Clear FSM state, sweep counter and registered busy flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            busy_r    <= (state_next_s == ST_CLEAR);
        end
    end

    // Clear FSM next state: one word per cycle until the last address.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        clear_we_s     = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clear_we_s = 1'b1;
                if (clr_cnt_r == {AWIDTH{1'b1}}) begin
                    state_next_s   = ST_IDLE;
                    clr_cnt_next_s = '0;
                end else begin
                    clr_cnt_next_s = clr_cnt_r + AWIDTH'(1);
                end
            end
            ST_IDLE: begin
                clear_we_s = 1'b0;
            end
            default: begin
                state_next_s   = ST_CLEAR;
                clr_cnt_next_s = '0;
            end
        endcase
    end

    assign busy_s     = busy_r;
    assign clr_addr_s = clr_cnt_r;
`else
    assign busy_s     = 1'b0;
    assign clear_we_s = 1'b0;
    assign clr_addr_s = '0;
`endif

    assign wb_ack_o       = ack_r;
    assign wb_dat_o       = dat_r;
    assign acc_rd_data_o  = acc_data_r;
    assign acc_rd_valid_o = acc_valid_r;
    assign busy_o         = busy_s;

endmodule

// File: tb/tb_dffram_wb_dp.sv
// Scoreboard bench for dffram_wb_dp; with DFFRAM_WB_DP_CLEAR_EN it runs AWIDTH 4 and the clear tests.
module tb_dffram_wb_dp;

`ifdef DFFRAM_WB_DP_CLEAR_EN
    localparam int TB_AW = 4;
`else
    localparam int TB_AW = 8;
`endif
    localparam int          TB_DEPTH = 1 << TB_AW;
    localparam logic [31:0] BASE     = 32'h3000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       dat_i, adr, dat_o;
    logic              ack;
    logic              acc_en;
    logic [TB_AW-1:0]  acc_addr;
    logic [23:0]       acc_data;
    logic              acc_valid;
    logic              busy;

    logic [23:0] model [TB_DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] acc_q [$];
    logic [31:0] tmp;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dffram_wb_dp #(.BASE_ADDRESS(BASE), .DWIDTH(24), .AWIDTH(TB_AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_adr_i(adr), .wb_ack_o(ack), .wb_dat_o(dat_o),
        .acc_rd_en_i(acc_en), .acc_rd_addr_i(acc_addr), .acc_rd_data_o(acc_data),
        .acc_rd_valid_o(acc_valid), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] apply_wr(input logic [23:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
        logic [23:0] r;
        r = old;
        for (int k = 0; k < 3; k++) begin
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // One Wishbone access with scoreboarded read data and single-pulse ack check.
    task automatic wb_xfer(input logic w, input int idx, input logic [31:0] d,
                           input logic [3:0] s, input string tag);
        logic got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + 32'(idx * 4); dat_i = d; sel = s;
        if (w) model[idx] = apply_wr(model[idx], d, s);
        else   exp_q.push_back({8'h00, model[idx]});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk({tag, "_ack"}, {31'h0, got}, 32'h1);
        if (!w) begin
            tmp = exp_q.pop_front();
            if (got) chk({tag, "_rd"}, dat_o, tmp);
        end
        @(posedge clk); #1;
        chk({tag, "_ack_pulse"}, {31'h0, ack}, 32'h0);
    endtask

    task automatic wb_miss(input logic [31:0] a, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk(tag, n, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", {31'h0, busy}, 32'h0);
        for (int i = 0; i < TB_DEPTH; i++) model[i] = 24'h0;
    endtask

    initial begin
        int n, na, nv;
        logic got;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = 32'h0; adr = 32'h0; acc_en = 1'b0; acc_addr = '0;
        for (int i = 0; i < TB_DEPTH; i++) model[i] = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_acc_data", {8'h0, acc_data}, 32'h0);
        chk("rst_acc_valid", {31'h0, acc_valid}, 32'h0);
`ifdef DFFRAM_WB_DP_CLEAR_EN
        chk("rst_busy", {31'h0, busy}, 32'h1);
`else
        chk("rst_busy", {31'h0, busy}, 32'h0);
`endif
        @(negedge clk); rst = 1'b0;
`ifdef DFFRAM_WB_DP_CLEAR_EN
        wait_idle();
`endif
        for (int i = 0; i < 16; i++) wb_xfer(1'b1, i, 32'h0A0B_0C00 + 32'(i), 4'hF, "init");
        wb_xfer(1'b1, TB_DEPTH - 1, 32'h00C0_FFEE, 4'hF, "init_top");

        wb_xfer(1'b1, 4, 32'hDEAD_BEEF, 4'hF, "wr_dead");
        wb_xfer(1'b0, 4, 32'h0, 4'hF, "rd_dead");
        chk("dead_value", dat_o, 32'h00AD_BEEF);

        wb_xfer(1'b1, 8, 32'h1122_3344, 4'hF, "wr_full");
        wb_xfer(1'b1, 8, 32'hAABB_CCDD, 4'b0010, "wr_lane1");
        wb_xfer(1'b0, 8, 32'h0, 4'hF, "rd_lane1");
        chk("lane1_value", dat_o, 32'h0022_CC44);
        wb_xfer(1'b1, 8, 32'hFFFF_FFFF, 4'b1000, "wr_lane3");
        wb_xfer(1'b1, 8, 32'hFFFF_FFFF, 4'b0000, "wr_sel0");
        wb_xfer(1'b0, 8, 32'h0, 4'h0, "rd_after_nop");

        wb_miss(BASE + 32'(1 << (TB_AW + 2)), "miss_above");
        wb_miss(BASE - 32'd4, "miss_below");
        wb_xfer(1'b0, 0, 32'h0, 4'hF, "rd_miss_w0");
        wb_xfer(1'b0, TB_DEPTH - 1, 32'h0, 4'hF, "rd_miss_top");

        // Held strobe: three accepts, one per two cycles, data stable between acks.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        repeat (3) exp_q.push_back({8'h00, model[4]});
        tmp = {8'h00, model[4]};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("held_ack", {31'h0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (ack && exp_q.size() > 0) chk("held_rd", dat_o, exp_q.pop_front());
            else chk("held_stable", dat_o, tmp);
        end
        cyc = 1'b0; stb = 1'b0;
        exp_q.delete();

        // Collision on word 5 plus master dropping stb right after the accept edge.
        wb_xfer(1'b1, 5, 32'h0000_0001, 4'hF, "wr_old5");
        @(negedge clk);
        acc_en = 1'b1; acc_addr = TB_AW'(5);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'd20; dat_i = 32'h0012_3456; sel = 4'hF;
        acc_q.push_back({8'h00, model[5]});
        model[5] = apply_wr(model[5], 32'h0012_3456, 4'hF);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("coll_ack", {31'h0, ack}, 32'h1);
        chk("coll_valid", {31'h0, acc_valid}, 32'h1);
        chk("coll_old", {8'h00, acc_data}, acc_q.pop_front());
        acc_q.push_back({8'h00, model[5]});
        @(posedge clk); #1;
        chk("coll_valid2", {31'h0, acc_valid}, 32'h1);
        chk("coll_new", {8'h00, acc_data}, acc_q.pop_front());
        chk("coll_ack_pulse", {31'h0, ack}, 32'h0);

        // Back-to-back accelerator stream over the low words.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acc_en = 1'b1; acc_addr = TB_AW'(i);
            acc_q.push_back({8'h00, model[i]});
            @(posedge clk); #1;
            chk("acc_valid", {31'h0, acc_valid}, 32'h1);
            chk("acc_data", {8'h00, acc_data}, acc_q.pop_front());
        end
        @(negedge clk); acc_en = 1'b0;
        @(posedge clk); #1;
        chk("acc_valid_off", {31'h0, acc_valid}, 32'h0);

        for (int r = 0; r < 40; r++) begin
            wb_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                    4'($urandom_range(0, 15)), "rand");
        end

        // Reset coinciding with a strobe must not ack.
        @(negedge clk);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        @(posedge clk); #1;
        chk("rst_mid_ack", {31'h0, ack}, 32'h0);
        @(negedge clk); rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack2", {31'h0, ack}, 32'h0);
`ifdef DFFRAM_WB_DP_CLEAR_EN
        wait_idle();
        for (int i = 0; i < TB_DEPTH; i++) wb_xfer(1'b1, i, 32'h0055_0000 + 32'(i + 1), 4'hF, "pre");

        // Clear sweep: busy for 16 cycles, Wishbone stalled, acc gives no valid.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd12; acc_en = 1'b1; acc_addr = TB_AW'(3);
        n = 0; na = 0; nv = 0;
        while (busy && n < 40) begin
            n++;
            if (ack) na++;
            if (acc_valid) nv++;
            @(posedge clk); #1;
        end
        acc_en = 1'b0;
        chk("clr_busy_len", n, 16);
        chk("clr_stall_ack", na, 0);
        chk("clr_acc_valid", nv, 0);
        for (int i = 0; i < TB_DEPTH; i++) model[i] = 24'h0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ack) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("clr_late_ack", {31'h0, got}, 32'h1);
        chk("clr_late_rd", dat_o, 32'h0);
        for (int i = 0; i < TB_DEPTH; i++) wb_xfer(1'b0, i, 32'h0, 4'hF, "clr_rd");

        // Reset seven cycles into a sweep restarts it.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("clr_restart_len", n, 16);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
